// File: rtl/fifo_pkg.sv
// Shared definitions for the 8-entry synchronous FIFO: state encoding and sizing.
// Used by the control stage and the address-calculation stage.
package fifo_pkg;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    INIT   = 3'b000,
    WRITE  = 3'b001,
    WR_ERR = 3'b010,
    NO_OP  = 3'b011,
    READ   = 3'b100,
    RD_ERR = 3'b101
  } state_t;

  // Codes 110 and 111 are never produced; seeing one means an upset or a bug.
  function automatic logic is_legal(input logic [2:0] s);
    return s <= 3'b101;
  endfunction

endpackage

// File: rtl/fifo_ns.sv
// Next-state selection for the FIFO control FSM. Full/empty decisions look at
// next_data_count so an operation still in flight is already accounted for.
module fifo_ns
  import fifo_pkg::*;
(
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [2:0]       state,
  input  logic [CNT_W-1:0] next_data_count,
  output logic [2:0]       next_state
);

  always_comb begin
    // NOTE: default assignment first so no path through this block can infer a latch.
    next_state = NO_OP;
    if (!is_legal(state)) begin
      next_state = INIT;
    end else if (wr_en && !rd_en) begin
      next_state = (next_data_count == CNT_W'(DEPTH)) ? WR_ERR : WRITE;
    end else if (!wr_en && rd_en) begin
      next_state = (next_data_count == '0) ? RD_ERR : READ;
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// Sequential control stage of the 8-entry FIFO: state, pointer and count registers
// plus user flags. Define FIFO_ALMOST_FLAGS_EN to add almost_full/almost_empty.
module fifo_ctrl
  import fifo_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [PTR_W-1:0] next_head,
  input  logic [PTR_W-1:0] next_tail,
  input  logic [CNT_W-1:0] next_data_count,
  output logic [2:0]       state,
  output logic [PTR_W-1:0] head,
  output logic [PTR_W-1:0] tail,
  output logic [CNT_W-1:0] data_count,
  output logic             full,
  output logic             empty,
  output logic             wr_ack,
  output logic             wr_err,
  output logic             rd_ack,
`ifdef FIFO_ALMOST_FLAGS_EN
  output logic             almost_full,
  output logic             almost_empty,
`endif
  output logic             rd_err
);

  logic [2:0] next_state;

  fifo_ns u_ns (
    .wr_en           (wr_en),
    .rd_en           (rd_en),
    .state           (state),
    .next_data_count (next_data_count),
    .next_state      (next_state)
  );

  // Reset clears every register, so a pending WRITE/READ cannot leave a partial update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= INIT;
      head       <= '0;
      tail       <= '0;
      data_count <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      state      <= next_state;
      head       <= next_head;
      tail       <= next_tail;
      data_count <= next_data_count;
    end
  end

  // Flags depend only on registered values: no combinational path from wr_en/rd_en.
  assign full   = (data_count == CNT_W'(DEPTH));
  assign empty  = (data_count == '0);
  assign wr_ack = (state == WRITE);
  assign wr_err = (state == WR_ERR);
  assign rd_ack = (state == READ);
  assign rd_err = (state == RD_ERR);

`ifdef FIFO_ALMOST_FLAGS_EN
  assign almost_full  = (data_count >= CNT_W'(DEPTH - 1));
  assign almost_empty = (data_count <= CNT_W'(1));
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: models the address-calc stage around the DUT and checks every
// cycle against a reference model through a scoreboard queue.
module tb_fifo_ctrl;
  import fifo_pkg::*;

`ifdef FIFO_ALMOST_FLAGS_EN
  localparam int VW = 21;
`else
  localparam int VW = 19;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr_en, rd_en;
  logic [2:0] next_head, next_tail;
  logic [3:0] next_data_count;
  logic [2:0] state, head, tail;
  logic [3:0] data_count;
  logic       full, empty, wr_ack, wr_err, rd_ack, rd_err;
`ifdef FIFO_ALMOST_FLAGS_EN
  logic       almost_full, almost_empty;
`endif

  fifo_ctrl dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .wr_en           (wr_en),
    .rd_en           (rd_en),
    .next_head       (next_head),
    .next_tail       (next_tail),
    .next_data_count (next_data_count),
    .state           (state),
    .head            (head),
    .tail            (tail),
    .data_count      (data_count),
    .full            (full),
    .empty           (empty),
    .wr_ack          (wr_ack),
    .wr_err          (wr_err),
    .rd_ack          (rd_ack),
`ifdef FIFO_ALMOST_FLAGS_EN
    .almost_full     (almost_full),
    .almost_empty    (almost_empty),
`endif
    .rd_err          (rd_err)
  );

  always #5 clk = ~clk;

  // Address-calc stage stand-in: advance a pointer and the count while WRITE/READ is pending.
  always_comb begin
    next_head       = head;
    next_tail       = tail;
    next_data_count = data_count;
    if (state == WRITE) begin
      next_tail       = tail + 3'd1;
      next_data_count = data_count + 4'd1;
    end else if (state == READ) begin
      next_head       = head + 3'd1;
      next_data_count = data_count - 4'd1;
    end
  end

  logic [VW-1:0] obs;
  assign obs = {state, head, tail, data_count, full, empty, wr_ack, wr_err, rd_ack, rd_err
`ifdef FIFO_ALMOST_FLAGS_EN
                , almost_full, almost_empty
`endif
               };

  int checks = 0;
  int errors = 0;
  logic [VW-1:0] sb[$];
  logic [VW-1:0] exp_v;

  logic [2:0] m_state, m_head, m_tail;
  logic [3:0] m_cnt;

  function automatic logic [VW-1:0] expect_vec(input logic [2:0] st, input logic [2:0] h,
                                               input logic [2:0] t, input logic [3:0] c);
    return {st, h, t, c, c == 4'd8, c == 4'd0, st == WRITE, st == WR_ERR, st == READ, st == RD_ERR
`ifdef FIFO_ALMOST_FLAGS_EN
            , c >= 4'd7, c <= 4'd1
`endif
           };
  endfunction

  task automatic reset_model();
    m_state = INIT;
    m_head  = '0;
    m_tail  = '0;
    m_cnt   = '0;
    sb.delete();
  endtask

  // Drive one request at the falling edge, predict the post-edge outputs, push them,
  // and return #1 after the rising edge.
  task automatic cycle(input logic wr, input logic rd);
    logic [3:0] n_cnt;
    logic [2:0] n_head, n_tail, n_state;
    @(negedge clk);
    wr_en = wr;
    rd_en = rd;
    n_cnt  = m_cnt;
    n_head = m_head;
    n_tail = m_tail;
    if (m_state == WRITE) begin
      n_cnt  = m_cnt + 4'd1;
      n_tail = m_tail + 3'd1;
    end
    if (m_state == READ) begin
      n_cnt  = m_cnt - 4'd1;
      n_head = m_head + 3'd1;
    end
    if (wr && !rd)      n_state = (n_cnt == 4'd8) ? WR_ERR : WRITE;
    else if (!wr && rd) n_state = (n_cnt == 4'd0) ? RD_ERR : READ;
    else                n_state = NO_OP;
    m_state = n_state;
    m_head  = n_head;
    m_tail  = n_tail;
    m_cnt   = n_cnt;
    sb.push_back(expect_vec(m_state, m_head, m_tail, m_cnt));
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    reset_model();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== expect_vec(INIT, 3'd0, 3'd0, 4'd0)) begin
      errors++;
      $display("FAIL reset_initial: got %h expected %h", obs, expect_vec(INIT, 3'd0, 3'd0, 4'd0));
    end
    reset_n = 1'b1;
    reset_model();
    // Four writes: WRITE is pending with data_count == 3.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0);
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL reset_prefill cyc %0d: got %h expected %h", i, obs, exp_v);
      end
    end
    checks++;
    if (state !== WRITE || data_count !== 4'd3) begin
      errors++;
      $display("FAIL reset_setup: got state %0d count %0d expected state 1 count 3", state, data_count);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (obs !== expect_vec(INIT, 3'd0, 3'd0, 4'd0)) begin
      errors++;
      $display("FAIL reset_async: got %h expected %h", obs, expect_vec(INIT, 3'd0, 3'd0, 4'd0));
    end
    wr_en = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (obs !== expect_vec(INIT, 3'd0, 3'd0, 4'd0)) begin
      errors++;
      $display("FAIL reset_hold: got %h expected %h", obs, expect_vec(INIT, 3'd0, 3'd0, 4'd0));
    end
    reset_n = 1'b1;
    reset_model();
  endtask

  task automatic test_fill();
    apply_reset();
    // Nine write requests then one idle so the final count is visible.
    for (int i = 0; i < 10; i++) begin
      cycle(i < 9, 1'b0);
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v || data_count > 4'd8) begin
        errors++;
        $display("FAIL fill cyc %0d: got %h expected %h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_drain();
    // Continues from the full FIFO left by test_fill.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, i < 9);
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL drain cyc %0d: got %h expected %h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    // 7 writes, idle to settle at 7, then two back-to-back writes and two idles.
    for (int i = 0; i < 12; i++) begin
      cycle((i < 7) || (i == 8) || (i == 9), 1'b0);
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v || data_count > 4'd8) begin
        errors++;
        $display("FAIL back_to_back cyc %0d: got %h expected %h", i, obs, exp_v);
      end
      if (i == 9) begin
        checks++;
        if (state !== WR_ERR) begin
          errors++;
          $display("FAIL back_to_back_err: got state %0d expected %0d", state, WR_ERR);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      cycle((i < 4) || (i == 5), i == 5);
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL simultaneous cyc %0d: got %h expected %h", i, obs, exp_v);
      end
      if (i == 5) begin
        checks++;
        if (state !== NO_OP || data_count !== 4'd4 || head !== 3'd0 || tail !== 3'd4) begin
          errors++;
          $display("FAIL simultaneous_hold: got state %0d count %0d head %0d tail %0d expected 3 4 0 4",
                   state, data_count, head, tail);
        end
      end
    end
  endtask

`ifdef FIFO_ALMOST_FLAGS_EN
  task automatic test_almost();
    apply_reset();
    // Fill to 7 one write at a time, then drain to 1, checking the flags every cycle.
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0);
      exp_v = sb.pop_front();
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v || almost_full !== (i >= 6)) begin
        errors++;
        $display("FAIL almost_full step %0d: got %h expected %h", i, obs, exp_v);
      end
    end
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b0);
      exp_v = sb.pop_front();
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v || almost_empty !== (i >= 5)) begin
        errors++;
        $display("FAIL almost_empty step %0d: got %h expected %h", i, obs, exp_v);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_simultaneous();
`ifdef FIFO_ALMOST_FLAGS_EN
    test_almost();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
